// File: rtl/rect_fall_ctl_pkg.sv
// -----------------------------------------------------------------------------
// rect_fall_ctl_pkg
// Shared screen geometry, controller state encoding and the saturating
// arithmetic helpers used by the gravity-drop position controller.
// -----------------------------------------------------------------------------
package rect_fall_ctl_pkg;

  // VGA screen geometry (800x600). The floor is the bottom screen line.
  localparam int SCREEN_W    = 800;
  localparam int SCREEN_H    = 600;
  localparam int VGA_Y_FLOOR = 600;

  // Position / velocity word width.
  localparam int POS_W = 12;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    STOP = 2'd3
  } state_t;

  // Clamp a 13-bit sum back into 12 bits (saturate at 4095).
  function automatic logic [11:0] sat12(input logic [12:0] v);
    return v[12] ? 12'hFFF : v[11:0];
  endfunction

  // a - b, floored at zero.
  function automatic logic [11:0] sat0_sub(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : 12'd0;
  endfunction

endpackage

// File: rtl/rect_fall_ctl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running motion tick generator. The counter runs 0..CLK_PER_TICK-1 and
// tick pulses for one cycle while the counter sits at its last value, so the
// consumer acts on the wrap edge. While clr is high the counter is held at 0
// and no tick is produced.
//
// Ports:
//   pclk  - clock
//   rst   - asynchronous active-low reset
//   clr   - synchronous clear / hold at zero
//   tick  - one-cycle pulse every CLK_PER_TICK cycles
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int CLK_PER_TICK = 400000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] r_cnt;

  // Tick period counter, held at zero while cleared.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/rect_fall_ctl.sv
// -----------------------------------------------------------------------------
// rect_fall_ctl
// Position controller between position_memory and draw_rect. While idle it
// forwards the mouse position with one cycle of latency. A left-click freezes
// x and runs a gravity drop of the rectangle with damped bounces until it
// rests on the floor (FLOOR_Y = Y_FLOOR - RECT_H). A click during the motion
// or at rest returns to mouse tracking.
//
// Ports:
//   pclk       - pixel clock
//   rst        - asynchronous active-low reset
//   mouse_left - left button, asynchronous to pclk
//   xpos_in    - mouse x from position_memory
//   ypos_in    - mouse y from position_memory
//   xpos_out   - rectangle x to draw_rect
//   ypos_out   - rectangle y to draw_rect
//   busy       - high whenever the controller is not idle
//   done       - one-cycle pulse when the rectangle comes to rest
// -----------------------------------------------------------------------------
module rect_fall_ctl
  import rect_fall_ctl_pkg::*;
#(
  parameter int CLK_PER_TICK = 400000,
  parameter int Y_FLOOR      = VGA_Y_FLOOR,
  parameter int RECT_H       = 48,
  parameter int G            = 1,
  parameter int V_MIN        = 2,
  parameter int DAMP_SHIFT   = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        busy,
  output logic        done
);

  localparam logic [12:0] FLOOR_Y = 13'(Y_FLOOR - RECT_H);
  localparam logic [11:0] FLOOR_Y12 = FLOOR_Y[11:0];
  localparam logic [12:0] G13     = 13'(G);
  localparam logic [11:0] G12     = 12'(G);
  localparam logic [11:0] V_MIN12 = 12'(V_MIN);

  state_t      r_state;
  logic        r_s1, r_s2, r_s3;
  logic [11:0] r_xpos, r_ypos, r_vel;
  logic        r_busy, r_done;

  logic        w_rise;
  logic        w_tick, w_tick_clr;
  logic [12:0] w_v_sum;
  logic [11:0] w_v_fall;
  logic [12:0] w_y_fall;
  logic [11:0] w_v_bounce;
  logic [11:0] w_v_rise;

  // Two-flop synchronizer for the button plus a history flop for edge detect.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= mouse_left;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // Motion ticks only run while falling or rising; holding the counter at
  // zero in IDLE/STOP makes the first tick land CLK_PER_TICK cycles after a
  // new drop starts.
  assign w_tick_clr = (r_state == IDLE) || (r_state == STOP);

  tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick_gen (
    .pclk (pclk),
    .rst  (rst),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  // Candidate next values. Sums are formed 13 bits wide so the floor compare
  // sees the true position even past 4095.
  assign w_v_sum    = {1'b0, r_vel} + G13;
  assign w_v_fall   = sat12(w_v_sum);
  assign w_y_fall   = {1'b0, r_ypos} + {1'b0, w_v_fall};
  assign w_v_bounce = w_v_fall >> DAMP_SHIFT;
  assign w_v_rise   = sat0_sub(r_vel, G12);

  // Controller FSM with registered position, velocity, busy and done.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_xpos  <= 12'd0;
      r_ypos  <= 12'd0;
      r_vel   <= 12'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_xpos <= xpos_in;
          r_ypos <= ypos_in;
          r_vel  <= 12'd0;
          if (w_rise) begin
            r_state <= FALL;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        FALL: begin
          // A click wins over a coincident tick: no position update.
          if (w_rise) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (w_y_fall >= FLOOR_Y) begin
              r_ypos <= FLOOR_Y12;
              r_vel  <= w_v_bounce;
              if (w_v_bounce < V_MIN12) begin
                r_state <= STOP;
                r_done  <= 1'b1;
              end else begin
                r_state <= RISE;
              end
            end else begin
              r_ypos <= w_y_fall[11:0];
              r_vel  <= w_v_fall;
            end
          end else begin
            r_state <= FALL;
          end
        end
        RISE: begin
          if (w_rise) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (r_vel > r_ypos) begin
              // Would leave the top of the screen: pin to 0 and fall back.
              r_ypos  <= 12'd0;
              r_vel   <= 12'd0;
              r_state <= FALL;
            end else begin
              r_ypos <= r_ypos - r_vel;
              r_vel  <= w_v_rise;
              if (r_vel <= G12) begin
                r_state <= FALL;
              end else begin
                r_state <= RISE;
              end
            end
          end else begin
            r_state <= RISE;
          end
        end
        STOP: begin
          if (w_rise) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= STOP;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign xpos_out = r_xpos;
  assign ypos_out = r_ypos;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_rect_fall_ctl.sv
// -----------------------------------------------------------------------------
// tb_rect_fall_ctl
// Self-checking bench for rect_fall_ctl with CLK_PER_TICK=4, FLOOR_Y=552.
// A behavioural model built from the drop/bounce rules tracks every cycle;
// directed sequences check the documented trajectories and corner cases.
// -----------------------------------------------------------------------------
module tb_rect_fall_ctl;

  localparam int TPC   = 4;
  localparam int FLOOR = 552;
  localparam int GV    = 1;
  localparam int VMIN  = 2;
  localparam int DS    = 1;

  localparam int M_IDLE = 0;
  localparam int M_FALL = 1;
  localparam int M_RISE = 2;
  localparam int M_STOP = 3;

  logic        pclk       = 1'b0;
  logic        rst        = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] xpos_in    = 12'd0;
  logic [11:0] ypos_in    = 12'd0;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  rect_fall_ctl #(
    .CLK_PER_TICK(TPC),
    .Y_FLOOR     (600),
    .RECT_H      (48),
    .G           (GV),
    .V_MIN       (VMIN),
    .DAMP_SHIFT  (DS)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .mouse_left(mouse_left),
    .xpos_in   (xpos_in),
    .ypos_in   (ypos_in),
    .xpos_out  (xpos_out),
    .ypos_out  (ypos_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 pclk = ~pclk;

  // ---------------- behavioural reference model ----------------
  int m_x = 0, m_y = 0, m_vel = 0, m_mode = M_IDLE, m_phase = 0;
  int m_busy = 0, m_done = 0;
  int m_btn[$];            // button samples, newest first
  int m_rise, m_tick, m_next, m_v, m_ny;

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      m_x = 0; m_y = 0; m_vel = 0; m_mode = M_IDLE; m_phase = 0;
      m_busy = 0; m_done = 0;
      m_btn = '{0, 0, 0};
    end else begin
      // A click is seen two edges after the button was sampled high,
      // provided it was low on the sample before.
      m_rise = (m_btn[1] == 1 && m_btn[2] == 0) ? 1 : 0;
      m_tick = ((m_mode == M_FALL || m_mode == M_RISE) && m_phase == TPC - 1) ? 1 : 0;
      m_next = m_mode;
      if (m_mode == M_IDLE) begin
        m_x = xpos_in; m_y = ypos_in; m_vel = 0;
        if (m_rise == 1) m_next = M_FALL;
      end else if (m_rise == 1) begin
        m_next = M_IDLE;
      end else if (m_tick == 1 && m_mode == M_FALL) begin
        m_v  = (m_vel + GV > 4095) ? 4095 : m_vel + GV;
        m_ny = m_y + m_v;
        if (m_ny >= FLOOR) begin
          m_y = FLOOR; m_vel = m_v / (1 << DS);
          m_next = (m_vel < VMIN) ? M_STOP : M_RISE;
        end else begin
          m_y = m_ny; m_vel = m_v;
        end
      end else if (m_tick == 1 && m_mode == M_RISE) begin
        if (m_vel > m_y) begin
          m_y = 0; m_vel = 0; m_next = M_FALL;
        end else begin
          if (m_vel <= GV) m_next = M_FALL;
          m_y = m_y - m_vel;
          m_vel = (m_vel > GV) ? m_vel - GV : 0;
        end
      end
      // Phase within the tick period: restarts on a new drop, otherwise wraps.
      if (m_mode != M_IDLE && (m_next == M_FALL || m_next == M_RISE))
        m_phase = (m_phase + 1) % TPC;
      else
        m_phase = 0;
      m_done = (m_next == M_STOP && m_mode != M_STOP) ? 1 : 0;
      m_busy = (m_next != M_IDLE) ? 1 : 0;
      m_mode = m_next;
      m_btn.push_front(mouse_left ? 1 : 0);
      m_btn = m_btn[0:2];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_x", xpos_out, m_x);
    check("model_y", ypos_out, m_y);
    check("model_busy", busy, m_busy);
    check("model_done", done, m_done);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    check_model();
  endtask

  task automatic click();
    mouse_left = 1'b1;
    step();
    step();
    mouse_left = 1'b0;
  endtask

  task automatic wait_busy(input int want);
    int n;
    n = 0;
    while (busy != want && n < 10) begin
      step();
      n++;
    end
    check("wait_busy", busy, want);
  endtask

  // Step n cycles; report cycles to the first y change, its value, and dones.
  task automatic first_move(input int n, output int gap, output int val, output int dcnt);
    int y0;
    y0 = ypos_out; gap = -1; val = -1; dcnt = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (done) dcnt++;
      if (gap < 0 && ypos_out != y0) begin
        gap = i; val = ypos_out;
      end
    end
  endtask

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          ex;
    int          ey;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int traj[$];
    int exp_traj[9];
    int lasty, gap, val, dcnt, n;

    tbl[0] = '{12'd100,  12'd200,  100,  200};
    tbl[1] = '{12'd0,    12'd0,    0,    0};
    tbl[2] = '{12'd4095, 12'd4095, 4095, 4095};
    tbl[3] = '{12'd799,  12'd599,  799,  599};
    tbl[4] = '{12'd100,  12'd540,  100,  540};
    exp_traj = '{541, 543, 546, 550, 552, 550, 549, 550, 552};

    // 1. reset state, then IDLE tracking from a vector table
    xpos_in = 12'd100; ypos_in = 12'd200;
    step(); step();
    check("rst_x", xpos_out, 0);
    check("rst_y", ypos_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge pclk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xpos_in = tbl[i].x; ypos_in = tbl[i].y;
      step();
      check("track_x", xpos_out, tbl[i].ex);
      check("track_y", ypos_out, tbl[i].ey);
      check("track_busy", busy, 0);
    end

    // 2/3. full drop from 540 with x frozen while xpos_in moves
    step();
    click();
    wait_busy(1);
    xpos_in = 12'd300;
    lasty = ypos_out; gap = -1; dcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (done) dcnt++;
      if (ypos_out != lasty) begin
        traj.push_back(ypos_out);
        if (gap < 0) gap = i;
        lasty = ypos_out;
      end
    end
    check("drop_first_tick_gap", gap, 4);
    check("drop_traj_len", traj.size(), 9);
    for (int i = 0; i < 9; i++)
      check("drop_traj", (i < traj.size()) ? traj[i] : -1, exp_traj[i]);
    check("drop_done_count", dcnt, 1);
    check("drop_stop_busy", busy, 1);
    check("drop_stop_y", ypos_out, 552);
    check("x_frozen", xpos_out, 100);

    // 4. start below the floor
    click();
    wait_busy(0);
    ypos_in = 12'd700;
    step(); step();
    check("below_track_y", ypos_out, 700);
    click();
    wait_busy(1);
    first_move(20, gap, val, dcnt);
    check("below_gap", gap, 4);
    check("below_y", val, 552);
    check("below_done", dcnt, 1);
    check("below_busy", busy, 1);
    check("below_x", xpos_out, 300);

    // 5. abort coincident with a tick
    click();
    wait_busy(0);
    xpos_in = 12'd100; ypos_in = 12'd100;
    step(); step(); step();
    click();
    wait_busy(1);
    for (int i = 0; i < 5; i++) step();
    mouse_left = 1'b1;
    step(); step();
    mouse_left = 1'b0;
    check("abort_pre_y", ypos_out, 101);
    step();
    check("abort_busy", busy, 0);
    check("abort_y_noupdate", ypos_out, 101);
    step();
    check("abort_track_x", xpos_out, 100);
    check("abort_track_y", ypos_out, 100);

    // 6. asynchronous reset mid-RISE, then a fresh drop
    ypos_in = 12'd540;
    step(); step();
    click();
    wait_busy(1);
    n = 0;
    while (ypos_out != 552 && n < 80) begin
      step();
      n++;
    end
    check("reach_floor", ypos_out, 552);
    step();
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_x", xpos_out, 0);
    check("async_rst_y", ypos_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge pclk);
    rst = 1'b1;
    xpos_in = 12'd100; ypos_in = 12'd540;
    step(); step();
    check("post_rst_busy", busy, 0);
    check("post_rst_y", ypos_out, 540);
    click();
    wait_busy(1);
    first_move(6, gap, val, dcnt);
    check("post_rst_gap", gap, 4);
    check("post_rst_y1", val, 541);

    // randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 7) == 0) begin
        xpos_in = 12'($urandom_range(0, 4095));
        ypos_in = ($urandom_range(0, 15) == 0) ? 12'($urandom_range(553, 4095))
                                               : 12'($urandom_range(0, 600));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
